// File: rtl/seq_pattern_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_detector_pkg
//  Description : Shared defaults and constants for the serial pattern detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pattern_detector_pkg;

    // Default pattern length in samples
    localparam int PAT_W_DEF = 4;

    // Default pattern after reset (MSB = oldest sample)
    localparam logic [3:0] PAT_RST_DEF = 4'b1101;

    // Default match-counter width
    localparam int CNT_W_DEF = 8;

    // Number of flops in each input synchronizer
    localparam int SYNC_DEPTH = 2;

endpackage : seq_pattern_detector_pkg
`default_nettype wire

// File: rtl/seq_pattern_detector_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-flop synchronizer followed by a registered rising-edge
//                pulse. The edge detector stays disarmed until the synchronizer
//                has been refilled after reset, so a level that is already high
//                when reset releases does not count as an edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge
    import seq_pattern_detector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic [SYNC_DEPTH-1:0] r_vld;
    logic                  r_prev;
    logic                  r_rise;

    // Synchronize the input and emit a one-cycle pulse on its 0->1 transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_vld  <= '0;
            r_prev <= 1'b1;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_d};
            r_vld  <= {r_vld[SYNC_DEPTH-2:0], 1'b1};
            if (r_vld[SYNC_DEPTH-1]) begin
                r_prev <= r_sync[SYNC_DEPTH-1];
            end
            r_rise <= r_vld[SYNC_DEPTH-1] & r_sync[SYNC_DEPTH-1] & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule : sync_edge
`default_nettype wire

// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_detector
//  Description : Serial bit-pattern detector. Each rising edge of the
//                asynchronous key input samples the asynchronous seq bit into
//                a history shift register; a full history equal to the loaded
//                pattern produces a hit pulse, sets led and bumps a saturating
//                match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector
    import seq_pattern_detector_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
    parameter int               CNT_W   = CNT_W_DEF,
    parameter int               OVERLAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key,
    input  logic             seq,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             pat_load,
    input  logic             cnt_clr,
    output logic             hit,
    output logic             led,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic                  w_strobe;
    logic [SYNC_DEPTH-1:0] r_seq_sync;
    logic                  r_seq_al;
    logic [PAT_W-1:0]      r_pat;
    logic [PAT_W-1:0]      r_hist;
    logic [FILL_W-1:0]     r_fill;
    logic                  r_hit;
    logic                  r_led;
    logic [CNT_W-1:0]      r_cnt;
    logic [PAT_W-1:0]      w_hist_next;
    logic [FILL_W-1:0]     w_fill_next;
    logic                  w_match;

    sync_edge u_key_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (key),
        .o_rise (w_strobe)
    );

    // seq synchronizer plus one extra stage so the bit lines up with the
    // registered key edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq_sync <= '0;
            r_seq_al   <= 1'b0;
        end else begin
            r_seq_sync <= {r_seq_sync[SYNC_DEPTH-2:0], seq};
            r_seq_al   <= r_seq_sync[SYNC_DEPTH-1];
        end
    end

    // History after shifting in the current sample at the LSB end
    generate
        if (PAT_W == 1) begin : g_hist_w1
            assign w_hist_next = r_seq_al;
        end else begin : g_hist_wn
            assign w_hist_next = {r_hist[PAT_W-2:0], r_seq_al};
        end
    endgenerate

    assign w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
    assign w_match     = (w_fill_next == FILL_FULL) && (w_hist_next == r_pat);

    // Pattern, history, fill and flag update; a pattern load overrides any
    // sample strobe in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat  <= PAT_RST;
            r_hist <= '0;
            r_fill <= '0;
            r_hit  <= 1'b0;
            r_led  <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (pat_load) begin
                r_pat  <= pat_in;
                r_hist <= '0;
                r_fill <= '0;
                r_led  <= 1'b0;
            end else if (w_strobe) begin
                r_hit <= w_match;
                r_led <= w_match;
                if (w_match && (OVERLAP == 0)) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= w_hist_next;
                    r_fill <= w_fill_next;
                end
            end
        end
    end

    // Saturating match counter driven by the hit pulse; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (r_hit && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign hit     = r_hit;
    assign led     = r_led;
    assign hit_cnt = r_cnt;

endmodule : seq_pattern_detector
`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_pattern_detector
//  Description : Directed bench for seq_pattern_detector. Four instances share
//                the stimulus: defaults (A), non-overlapping (B), 2-bit
//                counter (C) and single-sample pattern (D).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_detector;

    localparam logic [9:0] c_WIN_HIT = 10'b00_0000_1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       seq;
    logic [3:0] pat_in;
    logic       pat_load;
    logic       cnt_clr;

    logic       hit_a, led_a, hit_b, led_b, hit_c, led_c, hit_d, led_d;
    logic [7:0] cnt_a, cnt_b, cnt_d;
    logic [1:0] cnt_c;

    logic [9:0] win_a, win_b, win_c, win_d;
    int         n_vec  = 0;
    int         n_fail = 0;
    int         nh;

    always #5 clk = ~clk;

    seq_pattern_detector u_a (
        .clk(clk), .rst(rst), .key(key), .seq(seq), .pat_in(pat_in),
        .pat_load(pat_load), .cnt_clr(cnt_clr),
        .hit(hit_a), .led(led_a), .hit_cnt(cnt_a)
    );

    seq_pattern_detector #(.OVERLAP(0)) u_b (
        .clk(clk), .rst(rst), .key(key), .seq(seq), .pat_in(pat_in),
        .pat_load(pat_load), .cnt_clr(cnt_clr),
        .hit(hit_b), .led(led_b), .hit_cnt(cnt_b)
    );

    seq_pattern_detector #(.CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .key(key), .seq(seq), .pat_in(pat_in),
        .pat_load(pat_load), .cnt_clr(cnt_clr),
        .hit(hit_c), .led(led_c), .hit_cnt(cnt_c)
    );

    seq_pattern_detector #(.PAT_W(1), .PAT_RST(1'b1)) u_d (
        .clk(clk), .rst(rst), .key(key), .seq(seq), .pat_in(pat_in[0:0]),
        .pat_load(pat_load), .cnt_clr(cnt_clr),
        .hit(hit_d), .led(led_d), .hit_cnt(cnt_d)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One key press carrying bit b; records each instance's hit over the
    // 10 cycles following the first clock edge that sees key high.
    task automatic sample(input logic b, input bit clr_at_hit, input bit ld_at_strobe);
        @(negedge clk);
        seq = b;
        key = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            win_a[k] = hit_a;
            win_b[k] = hit_b;
            win_c[k] = hit_c;
            win_d[k] = hit_d;
            if (k == 2 && ld_at_strobe) pat_load = 1'b1;
            if (k == 3) pat_load = 1'b0;
            if (k == 3 && clr_at_hit) cnt_clr = 1'b1;
            if (k == 4) begin
                cnt_clr = 1'b0;
                key     = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; key = 1'b0; seq = 1'b0;
        pat_in = 4'b0000; pat_load = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hit_a", 16'(hit_a), 16'd0);
        check("rst_led_a", 16'(led_a), 16'd0);
        check("rst_cnt_a", 16'(cnt_a), 16'd0);
        check("rst_cnt_d", 16'(cnt_d), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Stream 1,1,0,1,1,0,1
        sample(1'b1, 1'b0, 1'b0);
        check("s1_win_a", 16'(win_a), 16'd0);
        check("s1_win_d", 16'(win_d), 16'(c_WIN_HIT));
        sample(1'b1, 1'b0, 1'b0);
        check("s2_win_d", 16'(win_d), 16'(c_WIN_HIT));
        check("s2_led_d", 16'(led_d), 16'd1);
        sample(1'b0, 1'b0, 1'b0);
        check("s3_win_a", 16'(win_a), 16'd0);
        sample(1'b1, 1'b0, 1'b0);
        check("s4_win_a", 16'(win_a), 16'(c_WIN_HIT));
        check("s4_win_b", 16'(win_b), 16'(c_WIN_HIT));
        check("s4_led_a", 16'(led_a), 16'd1);
        check("s4_cnt_a", 16'(cnt_a), 16'd1);
        check("s4_cnt_c", 16'(cnt_c), 16'd1);
        sample(1'b1, 1'b0, 1'b0);
        check("s5_win_a", 16'(win_a), 16'd0);
        check("s5_led_a", 16'(led_a), 16'd0);
        sample(1'b0, 1'b0, 1'b0);
        sample(1'b1, 1'b0, 1'b0);
        check("s7_win_a", 16'(win_a), 16'(c_WIN_HIT));
        check("s7_win_b", 16'(win_b), 16'd0);
        check("s7_cnt_a", 16'(cnt_a), 16'd2);
        check("s7_cnt_b", 16'(cnt_b), 16'd1);
        check("s7_cnt_c", 16'(cnt_c), 16'd2);

        // Three more 1101 matches: 2-bit counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            sample(1'b1, 1'b0, 1'b0);
            sample(1'b1, 1'b0, 1'b0);
            sample(1'b0, 1'b0, 1'b0);
            sample(1'b1, 1'b0, 1'b0);
            check("sat_cnt_c", 16'(cnt_c), 16'd3);
        end
        check("pre_clr_cnt_a", 16'(cnt_a), 16'd5);

        // Clear coincident with a hit
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b0, 1'b0, 1'b0);
        sample(1'b1, 1'b1, 1'b0);
        check("clr_win_a", 16'(win_a), 16'(c_WIN_HIT));
        check("clr_cnt_a", 16'(cnt_a), 16'd0);
        check("clr_cnt_c", 16'(cnt_c), 16'd0);

        // Pattern load coincident with a strobe (bit 0 is discarded)
        pat_in = 4'b0110;
        sample(1'b0, 1'b0, 1'b1);
        check("ld_win_a", 16'(win_a), 16'd0);
        check("ld_led_a", 16'(led_a), 16'd0);
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b0, 1'b0, 1'b0);
        check("ld_discard_win_a", 16'(win_a), 16'd0);
        check("ld_discard_win_b", 16'(win_b), 16'd0);
        sample(1'b0, 1'b0, 1'b0);
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b0, 1'b0, 1'b0);
        check("p0110_win_a", 16'(win_a), 16'(c_WIN_HIT));
        check("p0110_win_b", 16'(win_b), 16'(c_WIN_HIT));
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b1, 1'b0, 1'b0);
        check("p1101_b2_win_a", 16'(win_a), 16'd0);
        sample(1'b0, 1'b0, 1'b0);
        check("p1101_ovl_win_a", 16'(win_a), 16'(c_WIN_HIT));
        check("p1101_b3_win_b", 16'(win_b), 16'd0);
        sample(1'b1, 1'b0, 1'b0);
        check("p1101_b4_win_a", 16'(win_a), 16'd0);
        check("p1101_b4_win_b", 16'(win_b), 16'd0);
        check("ld_cnt_d", 16'(cnt_d), 16'd4);

        // Single-sample pattern (now 0): key held 50 cycles, seq toggling
        sample(1'b1, 1'b0, 1'b0);
        check("w1_one_win_d", 16'(win_d), 16'd0);
        @(negedge clk);
        seq = 1'b0;
        key = 1'b1;
        nh  = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            nh = nh + int'(hit_d);
            if (k >= 2) seq = ~seq;
        end
        key = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            nh = nh + int'(hit_d);
        end
        check("held_hits_d", 16'(nh), 16'd1);
        check("held_cnt_d", 16'(cnt_d), 16'd5);

        // Reset mid-sequence with key held high through release
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        seq = 1'b1;
        key = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_hit_a", 16'(hit_a), 16'd0);
        check("mid_rst_led_a", 16'(led_a), 16'd0);
        check("mid_rst_cnt_a", 16'(cnt_a), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        key = 1'b0;
        repeat (4) @(negedge clk);
        sample(1'b1, 1'b0, 1'b0);
        check("post_rst_s1_win_a", 16'(win_a), 16'd0);
        sample(1'b0, 1'b0, 1'b0);
        check("post_rst_s2_win_a", 16'(win_a), 16'd0);
        sample(1'b1, 1'b0, 1'b0);
        check("post_rst_s3_win_a", 16'(win_a), 16'd0);
        check("post_rst_cnt_a", 16'(cnt_a), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_seq_pattern_detector
`default_nettype wire

// File: doc/seq_pattern_detector.md
SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in samples (legal 1..16).
REQ-002 Parameter PAT_RST, default 4'b1101, pattern value after reset (PAT_W bits, MSB = oldest sample).
REQ-003 Parameter CNT_W, default 8, match-counter width (legal 1..16).
REQ-004 Parameter OVERLAP, default 1, 1 = overlapping matches allowed, 0 = each sample belongs to at most one match.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 key  input  1  debounced sample-enable level, asynchronous to clk; each rising edge requests one sample.
REQ-008 seq  input  1  serial data bit, asynchronous to clk, held stable around key rising edge.
REQ-009 pat_in  input  PAT_W  new pattern value.
REQ-010 pat_load  input  1  synchronous one-cycle strobe; loads pat_in.
REQ-011 cnt_clr  input  1  synchronous one-cycle strobe; clears hit_cnt.
REQ-012 hit  output  1  one-cycle pulse on each detected match.
REQ-013 led  output  1  high from a match until the next accepted sample.
REQ-014 hit_cnt  output  CNT_W  number of matches since reset/clear, saturating.

Function
REQ-015 key and seq SHALL each pass through a 2-flop synchronizer; an internal one-cycle sample strobe SHALL fire on the first cycle the synchronized key is 1 after being 0.
REQ-016 On a sample strobe the synchronized seq bit SHALL shift into a PAT_W-bit history register at the LSB end.
REQ-017 A fill counter (0..PAT_W, saturating) SHALL increment on each accepted sample; a match requires fill = PAT_W (after the shift) and history = pattern.
REQ-018 hit SHALL assert exactly 3 clk cycles after the first rising clk edge at which key is sampled high, for exactly one cycle, when that sample completes a match.
REQ-019 OVERLAP=1: fill SHALL remain at PAT_W after a match; OVERLAP=0: fill and history SHALL reset to 0 on the match cycle.
REQ-020 led SHALL set in the hit cycle and clear on the next accepted sample that does not itself match; a matching sample keeps led high.
REQ-021 hit_cnt SHALL increment by 1 per hit and hold at all-ones on overflow.
REQ-022 cnt_clr SHALL set hit_cnt to 0 next cycle; cnt_clr coincident with hit SHALL give 0 (clear wins).
REQ-023 pat_load SHALL update the pattern next cycle and clear history, fill and led; a sample strobe in the same cycle SHALL be discarded, no hit.
REQ-024 key held high SHALL produce only one sample; a key pulse shorter than 2 clk cycles MAY be missed.
REQ-025 PAT_W=1 SHALL match on every sample equal to pattern bit 0.

Reset
REQ-026 While rst is high: synchronizers 0, history 0, fill 0, pattern = PAT_RST, hit 0, led 0, hit_cnt 0.
REQ-027 rst asserted mid-sequence SHALL discard the partial history; key high at release SHALL NOT create a sample until key goes low then high.

Structure
REQ-028 Shared package SHALL hold default PAT_W, PAT_RST, CNT_W and the synchronizer depth constant (2).
REQ-029 One sub-module sync_edge (2-flop synchronizer + rising-edge pulse, same clk/rst) SHALL be instantiated for key; seq uses the synchronizer portion only, aligned to it.
REQ-030 No other clock and no derived clock SHALL be used; sampling is strobe-enabled on clk.

Verification
REQ-031 Defaults, samples 1,1,0,1 -> hit one pulse 3 cycles after 4th key edge, led 1, hit_cnt 1.
REQ-032 OVERLAP=1, samples 1,1,0,1,1,0,1 -> hits on samples 4 and 7, hit_cnt 2; OVERLAP=0 same stream -> hit on sample 4 only, hit_cnt 1.
REQ-033 CNT_W=2, 5 separate 1101 matches -> hit_cnt 1,2,3,3,3; then cnt_clr coincident with a hit -> hit_cnt 0.
REQ-034 pat_load pat_in=4'b0110 coincident with a strobe -> strobe ignored, led 0; then samples 0,1,1,0 -> hit, samples 1,1,0,1 -> no hit.
REQ-035 rst pulsed after samples 1,1,0 with key held high, then key low/high with seq=1 -> no hit; fill 1.
REQ-036 key held high 50 cycles with seq toggling -> exactly one sample accepted.
